// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM stage: issues a req/ack access,
// freezes the pipeline while it is outstanding, and returns load data / timeout status.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [31:0]       stall_cnt_o
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             err_flag;
  logic             acc;

  assign acc = mem_read_i | mem_write_i;

  // Gated by reset so the freeze releases immediately, not at the next edge.
  assign stall_o = rst_i & (((state == IDLE) & acc) | (state == REQ));
  assign err_o   = (state == DONE) & err_flag;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      err_flag    <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            state       <= REQ;
            mem_req_o   <= 1'b1;
            mem_we_o    <= mem_write_i;
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            cnt         <= '0;
            err_flag    <= 1'b0;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            if (!mem_we_o) rdata_o <= mem_rdata_i;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            // Abort: the load result is forced to zero and flagged for one cycle.
            state     <= DONE;
            mem_req_o <= 1'b0;
            rdata_o   <= '0;
            err_flag  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          err_flag <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      stall_cnt_o <= '0;
    else if (stall_o && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random accesses checked against a
// transaction-level model (stalls, request length, error pulse, load data, stall count).
module tb_mem_access_ctrl;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_read_i, mem_write_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, err_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i, stall_cnt_o;
  logic        mem_ack_i;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] model_rdata;
  logic [31:0] model_cnt;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // One instruction in EX/MEM; ack_cyc = REQ cycle (1-based) carrying the ack.
  task automatic run_access(input string name, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_cyc, input logic [31:0] rd_val);
    int stalls = 0, reqs = 0, errs = 0, bad_bus = 0, guard = 0;
    int exp_req, exp_stall;
    bit exp_err, done = 0;
    logic [31:0] got_rdata = '0;
    mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = wd;
    while (!done && guard < 40) begin
      @(negedge clk_i);
      guard++;
      if (stall_o === 1'b1) stalls++;
      if (err_o === 1'b1) errs++;
      if (mem_req_o === 1'b1) begin
        reqs++;
        if (mem_we_o !== wr || mem_addr_o !== a || (wr && mem_wdata_o !== wd)) bad_bus++;
      end
      if (stall_o === 1'b0 && mem_req_o === 1'b0) begin
        done = 1;
        got_rdata = rdata_o;
      end
      mem_ack_i   = (mem_req_o === 1'b1) && (reqs == ack_cyc);
      mem_rdata_i = mem_ack_i ? rd_val : $urandom;
      @(posedge clk_i); #1;
    end
    mem_read_i = 0; mem_write_i = 0; mem_ack_i = 0;

    exp_req   = (ack_cyc <= TO) ? ack_cyc : TO;
    exp_err   = (ack_cyc > TO);
    exp_stall = 1 + exp_req;
    if (exp_err) model_rdata = '0;
    else if (rd && !wr) model_rdata = rd_val;
    model_cnt = model_cnt + 32'(exp_stall);

    n_cmp++;
    if (!done) begin n_fail++; $display("FAIL %s completion: not done in 40 cycles, required done", name); end
    n_cmp++;
    if (stalls !== exp_stall) begin n_fail++; $display("FAIL %s stall_cycles: got %0d required %0d", name, stalls, exp_stall); end
    n_cmp++;
    if (reqs !== exp_req) begin n_fail++; $display("FAIL %s req_cycles: got %0d required %0d", name, reqs, exp_req); end
    n_cmp++;
    if (errs !== int'(exp_err)) begin n_fail++; $display("FAIL %s err_pulses: got %0d required %0d", name, errs, exp_err); end
    n_cmp++;
    if (bad_bus !== 0) begin n_fail++; $display("FAIL %s bus_stable: got %0d bad cycles required 0", name, bad_bus); end
    n_cmp++;
    if (got_rdata !== model_rdata) begin n_fail++; $display("FAIL %s rdata: got %h required %h", name, got_rdata, model_rdata); end
    n_cmp++;
    if (stall_cnt_o !== model_cnt) begin n_fail++; $display("FAIL %s stall_cnt: got %0d required %0d", name, stall_cnt_o, model_cnt); end
  endtask

  task automatic test_reset();
    rst_i = 0; mem_read_i = 0; mem_write_i = 0; addr_i = 0; wdata_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({mem_req_o, mem_we_o, err_o, stall_o} !== 4'b0 || mem_addr_o !== 0 || mem_wdata_o !== 0 ||
        rdata_o !== 0 || stall_cnt_o !== 0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b we=%b err=%b stall=%b addr=%h wdata=%h rdata=%h cnt=%0d required all 0",
               mem_req_o, mem_we_o, err_o, stall_o, mem_addr_o, mem_wdata_o, rdata_o, stall_cnt_o);
    end
    rst_i = 1;
    model_rdata = 0; model_cnt = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_read();
    run_access("read_ack3", 1, 0, 32'h40, 32'h0, 3, 32'hDEADBEEF);
  endtask

  task automatic test_write();
    run_access("write_ack1", 0, 1, 32'h10, 32'h1234, 1, 32'h5555AAAA);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_load", 1, 0, 32'h80, 32'h0, 1, 32'hCAFEF00D);
    run_access("b2b_store", 0, 1, 32'h84, 32'h99, 1, 32'h0);
  endtask

  task automatic test_both_bits();
    run_access("read_and_write", 1, 1, 32'hC0, 32'hABCD, 2, 32'h11111111);
  endtask

  task automatic test_timeout();
    run_access("load_for_timeout", 1, 0, 32'h20, 32'h0, 1, 32'h77777777);
    run_access("timeout_read", 1, 0, 32'h24, 32'h0, 1000, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit rd, wr;
      int k;
      rd = $urandom_range(0, 1);
      wr = rd ? $urandom_range(0, 1) : 1'b1;
      k  = $urandom_range(1, TO + 2);
      run_access($sformatf("rand%0d", i), rd, wr, $urandom, $urandom, k, $urandom);
    end
  endtask

  task automatic test_reset_mid_req();
    mem_read_i = 1; addr_i = 32'h300;
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_i = 0;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || stall_cnt_o !== 32'd0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_req: req=%b stall=%b cnt=%0d err=%b required 0 0 0 0",
               mem_req_o, stall_o, stall_cnt_o, err_o);
    end
    mem_read_i = 0;
    @(negedge clk_i);
    rst_i = 1;
    model_rdata = 0; model_cnt = 0;
    @(posedge clk_i); #1;
    run_access("after_reset_read", 1, 0, 32'h304, 32'h0, 2, 32'h0BADF00D);
  endtask

  task automatic test_alu_stream();
    int bad = 0;
    logic [31:0] cnt0;
    cnt0 = stall_cnt_o;
    for (int i = 0; i < 12; i++) begin
      mem_read_i = 0; mem_write_i = 0; addr_i = $urandom; wdata_i = $urandom;
      mem_ack_i = (i == 5) || ($urandom_range(0, 3) == 0);
      mem_rdata_i = $urandom;
      @(negedge clk_i);
      if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || err_o !== 1'b0) bad++;
      @(posedge clk_i); #1;
    end
    mem_ack_i = 0;
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL alu_stream_quiet: got %0d active cycles required 0", bad); end
    n_cmp++;
    if (stall_cnt_o !== cnt0) begin n_fail++; $display("FAIL alu_stream_cnt: got %0d required %0d", stall_cnt_o, cnt0); end
    n_cmp++;
    if (rdata_o !== model_rdata) begin n_fail++; $display("FAIL alu_stream_rdata: got %h required %h", rdata_o, model_rdata); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_both_bits();
    test_timeout();
    test_alu_stream();
    test_random();
    test_reset_mid_req();
    test_alu_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
